// File: rtl/hack_fetch_unit_pkg.sv
// Shared types and constants for the Hack instruction-fetch stage.
package hack_fetch_unit_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_VECTOR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

endpackage

// File: rtl/hack_fetch_unit_if.sv
// ROM read channel (req/ack) and decode channel (valid/ready) of the fetch stage.
interface hack_fetch_unit_if;
  import hack_fetch_unit_pkg::*;

  logic              rom_req;
  logic [WORD_W-1:0] rom_addr;
  logic              rom_ack;
  logic [WORD_W-1:0] rom_data;

  logic              instr_valid;
  logic              instr_ready;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] instr_pc;

  // fetch unit side
  modport master (
    output rom_req, rom_addr, instr_valid, instr, instr_pc,
    input  rom_ack, rom_data, instr_ready
  );

  // ROM / decode side
  modport slave (
    input  rom_req, rom_addr, instr_valid, instr, instr_pc,
    output rom_ack, rom_data, instr_ready
  );

endinterface

// File: rtl/hack_fetch_unit_inc16.sv
// Inc16: 16-bit incrementer, wraps FFFF -> 0000 with no carry out.
module hack_fetch_unit_inc16
  import hack_fetch_unit_pkg::*;
(
  input  logic [WORD_W-1:0] in_word,
  output logic [WORD_W-1:0] out_word
);

  assign out_word = in_word + WORD_W'(1);

endmodule

// File: rtl/hack_fetch_unit.sv
// Hack CPU fetch stage: owns the PC, issues ROM reads, hands words to decode.
//
// state    | meaning
// ST_IDLE  | no request outstanding, waiting for en
// ST_FETCH | rom_req high at pc, waiting for rom_ack or timeout
// ST_HOLD  | instr_valid high, waiting for decode to take the word
// ST_ERR   | ROM timed out; frozen until reset
module hack_fetch_unit
  import hack_fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned       TIMEOUT      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              jmp,
  input  logic [WORD_W-1:0] jmp_addr,
  output logic              fetch_err,
  hack_fetch_unit_if.master bus
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rom_req_q, rom_req_d;
  logic [WORD_W-1:0] rom_addr_q, rom_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] instr_pc_q, instr_pc_d;
  logic              fetch_err_q, fetch_err_d;
  logic              redirect;

  hack_fetch_unit_inc16 u_inc16 (
    .in_word  (pc_q),
    .out_word (pc_inc)
  );

  assign redirect = jmp && (state_q != ST_ERR);

  // next-pc mux: jump beats increment beats hold
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = jmp_addr;
    end else if ((state_q == ST_FETCH) && bus.rom_ack) begin
      pc_d = pc_inc;
    end
  end

  // next state and registered outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rom_req_d     = rom_req_q;
    rom_addr_d    = rom_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_err_d   = fetch_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en && !fetch_err_q) begin
          state_d    = ST_FETCH;
          rom_req_d  = 1'b1;
          rom_addr_d = pc_q;
          cnt_d      = '0;
        end
      end
      ST_FETCH: begin
        if (bus.rom_ack) begin
          state_d       = ST_HOLD;
          instr_d       = bus.rom_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          rom_req_d     = 1'b0;
          rom_addr_d    = '0;
          cnt_d         = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_ERR;
          fetch_err_d = 1'b1;
          rom_req_d   = 1'b0;
          rom_addr_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          if (en) begin
            state_d    = ST_FETCH;
            rom_req_d  = 1'b1;
            rom_addr_d = pc_q;
            cnt_d      = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        rom_req_d     = 1'b0;
        instr_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // A jump squashes any in-flight word. Out of FETCH it routes through IDLE
    // so rom_req drops for a cycle and the ROM sees a clean new request.
    if (redirect) begin
      cnt_d         = '0;
      instr_valid_d = 1'b0;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      if (state_q == ST_FETCH || !en) begin
        state_d    = ST_IDLE;
        rom_req_d  = 1'b0;
        rom_addr_d = '0;
      end else begin
        state_d    = ST_FETCH;
        rom_req_d  = 1'b1;
        rom_addr_d = jmp_addr;
      end
    end
  end

  // state, pc and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VECTOR;
      cnt_q         <= '0;
      rom_req_q     <= 1'b0;
      rom_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      rom_req_q     <= rom_req_d;
      rom_addr_q    <= rom_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign bus.rom_req     = rom_req_q;
  assign bus.rom_addr    = rom_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign fetch_err       = fetch_err_q;

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Self-checking bench for hack_fetch_unit: ROM/decode driven procedurally,
// expected {pc, word} pairs queued at ack time and compared at handshake.
module tb_hack_fetch_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic        jmp;
  logic [15:0] jmp_addr;
  logic        fetch_err;

  hack_fetch_unit_if bus();

  hack_fetch_unit #(
    .RESET_VECTOR (16'h0000),
    .TIMEOUT      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr),
    .fetch_err (fetch_err),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_pc;
  logic [31:0] sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_req"},   bus.rom_req,     0);
    check_val({tag, "_addr"},  bus.rom_addr,    0);
    check_val({tag, "_valid"}, bus.instr_valid, 0);
    check_val({tag, "_instr"}, bus.instr,       0);
    check_val({tag, "_ipc"},   bus.instr_pc,    0);
    check_val({tag, "_err"},   fetch_err,       0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.rom_req && n < 20) begin
      step();
      n++;
    end
    if (!bus.rom_req) check_val("req_timeout", bus.rom_req, 1);
  endtask

  // ROM answers the current request on its lat-th cycle
  task automatic rom_ack_after(input int lat, input logic [15:0] data);
    wait_req();
    check_val("rom_addr", bus.rom_addr, exp_pc);
    for (int i = 1; i < lat; i++) begin
      step();
      check_val("req_hold", bus.rom_req, 1);
    end
    bus.rom_ack  = 1'b1;
    bus.rom_data = data;
    sb_q.push_back({exp_pc, data});
    exp_pc = exp_pc + 16'd1;
    step();
    bus.rom_ack  = 1'b0;
    bus.rom_data = 16'h0000;
    check_val("ack_to_valid", bus.instr_valid, 1);
  endtask

  // decode stalls for hold_cyc cycles, then takes the word
  task automatic consume(input int hold_cyc);
    int          n = 0;
    logic [31:0] e;
    while (!bus.instr_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.instr_valid) begin
      check_val("valid_timeout", bus.instr_valid, 1);
      return;
    end
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", sb_q.size(), 1);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < hold_cyc; i++) begin
      check_val("hold_instr", {bus.instr_pc, bus.instr}, e);
      step();
      check_val("hold_valid", bus.instr_valid, 1);
      check_val("hold_no_req", bus.rom_req, 0);
    end
    check_val("instr", bus.instr, {16'h0000, e[15:0]});
    check_val("instr_pc", bus.instr_pc, {16'h0000, e[31:16]});
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset           = 1'b1;
    en              = 1'b0;
    jmp             = 1'b0;
    jmp_addr        = 16'h0000;
    bus.rom_ack     = 1'b0;
    bus.rom_data    = 16'h0000;
    bus.instr_ready = 1'b0;
    exp_pc          = 16'h0000;
    #1;
    check_outputs_zero("rst");
    step();
    step();
    reset = 1'b0;

    // basic fetch with ack latency 2 and a 5-cycle decode stall
    en = 1'b1;
    rom_ack_after(2, 16'hA5A5);
    consume(5);

    // back-to-back fetches, varied latency and data
    for (int k = 0; k < 3; k++) begin
      rom_ack_after(k + 1, 16'($urandom));
      consume(k);
    end

    // jump in FETCH without ack: one-cycle req drop, reissue at target
    wait_req();
    jmp = 1'b1; jmp_addr = 16'hFFFF;
    step();
    jmp = 1'b0;
    check_val("jmp_drop_req", bus.rom_req, 0);
    check_val("jmp_drop_valid", bus.instr_valid, 0);
    step();
    check_val("jmp_reissue", bus.rom_req, 1);
    exp_pc = 16'hFFFF;
    rom_ack_after(1, 16'h1234);
    consume(0);

    // wrapped fetch at 0000 with a jump in the ack cycle: word discarded
    wait_req();
    check_val("wrap_addr", bus.rom_addr, exp_pc);
    bus.rom_ack = 1'b1; bus.rom_data = 16'hDEAD;
    jmp = 1'b1; jmp_addr = 16'h0100;
    step();
    bus.rom_ack = 1'b0; jmp = 1'b0;
    check_val("jmp_ack_no_valid", bus.instr_valid, 0);
    check_val("jmp_ack_req_drop", bus.rom_req, 0);
    step();
    check_val("jmp_ack_no_valid2", bus.instr_valid, 0);
    check_val("jmp_ack_req", bus.rom_req, 1);
    exp_pc = 16'h0100;
    rom_ack_after(3, 16'h0F0F);
    consume(1);

    // en dropped mid-fetch: request completes, nothing follows
    wait_req();
    en = 1'b0;
    rom_ack_after(2, 16'h7E57);
    consume(0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("idle_no_req", bus.rom_req, 0);
      check_val("idle_no_valid", bus.instr_valid, 0);
    end

    // jump in HOLD with decode stalled: held word squashed
    en = 1'b1;
    rom_ack_after(1, 16'h5151);
    bus.instr_ready = 1'b0;
    jmp = 1'b1; jmp_addr = 16'h0200;
    step();
    jmp = 1'b0;
    check_val("squash_valid", bus.instr_valid, 0);
    check_val("squash_req", bus.rom_req, 1);
    void'(sb_q.pop_front());
    exp_pc = 16'h0200;
    rom_ack_after(2, 16'h2020);
    consume(0);

    // ROM never answers: fetch_err after TIMEOUT cycles of request
    wait_req();
    n = 0;
    while (bus.rom_req && n < 20) begin
      n++;
      step();
    end
    check_val("timeout_cycles", n, 8);
    check_val("timeout_err", fetch_err, 1);
    check_val("timeout_req", bus.rom_req, 0);
    jmp = 1'b1; jmp_addr = 16'h0300;
    for (int i = 0; i < 3; i++) step();
    jmp = 1'b0;
    step();
    check_val("err_sticky", fetch_err, 1);
    check_val("err_no_req", bus.rom_req, 0);
    check_val("err_no_valid", bus.instr_valid, 0);

    // reset out of ERR, then async reset in the middle of a fetch
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("err_cleared", fetch_err, 0);
    exp_pc = 16'h0000;
    wait_req();
    check_val("refetch_addr0", bus.rom_addr, 16'h0000);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    step();
    reset = 1'b0;
    sb_q.delete();
    rom_ack_after(2, 16'hBEEF);
    consume(0);
    check_val("sb_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
